// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// instr_fetch_ctrl: PC sequencer for a 1-cycle-latency instruction ROM with a
// 2-entry return buffer, valid/ready decode handoff, redirect flush and fault.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  output logic        IM_EN,
  output logic [31:0] IM_ADDR,
  input  logic [31:0] IM_INSTR,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        FAULT,
  output logic        BUSY
);

  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic [31:0] fifo_instr [2];
  logic [31:0] fifo_pc    [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;

  logic pop, credit, in_range, issue, redirect_ok, flush, push, fifo_pop;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    issue       = 1'b0;
    pop         = INSTR_VALID & INSTR_READY;
    credit      = (({1'b0, count} + {2'b00, inflight}) - {2'b00, pop}) < 3'(FIFO_DEPTH);
    in_range    = {1'b0, pc} < MEM_BYTES;
    redirect_ok = (REDIRECT_PC[1:0] == 2'b00);
    flush       = REDIRECT & (state != S_FAULT);
    case (state)
      S_IDLE: begin
        if (REDIRECT && redirect_ok) pc_nxt = REDIRECT_PC;
        if (START) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (REDIRECT) begin
          // A misaligned target flushes but leaves the PC untouched.
          if (redirect_ok) pc_nxt = REDIRECT_PC;
          else             state_nxt = S_FAULT;
        end else if (credit) begin
          if (in_range) begin
            issue  = 1'b1;
            pc_nxt = pc + 32'd4;
          end else begin
            state_nxt = S_FAULT;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  assign IM_EN   = issue;
  assign IM_ADDR = pc;
  assign BUSY    = (state == S_FETCH);
  assign FAULT   = (state == S_FAULT);

  // With the buffer empty, the returning word is presented straight to decode.
  assign INSTR_VALID = (count != 2'd0) | inflight;
  assign INSTR       = (count != 2'd0) ? fifo_instr[rd_ptr] : (inflight ? IM_INSTR : 32'h0);
  assign INSTR_PC    = (count != 2'd0) ? fifo_pc[rd_ptr]    : (inflight ? inflight_pc : 32'h0);

  assign fifo_pop = pop & (count != 2'd0);
  assign push     = inflight & ~(pop & (count == 2'd0));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_instr[i] <= 32'h0;
        fifo_pc[i]    <= 32'h0;
      end
    end else begin
      pc       <= pc_nxt;
      inflight <= issue;
      if (issue) inflight_pc <= pc;
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          fifo_instr[wr_ptr] <= IM_INSTR;
          fifo_pc[wr_ptr]    <= inflight_pc;
          wr_ptr             <= ~wr_ptr;
        end
        if (fifo_pop) rd_ptr <= ~rd_ptr;
        count <= (count + {1'b0, push}) - {1'b0, fifo_pop};
      end
    end
  end

endmodule
`default_nettype wire
